// File: rtl/vend_change_fsm_pkg.sv
// vend_pkg: shared types and helpers for the vending change controller.
//   vend_state_e : controller states (IDLE, COLLECT, VEND, CHANGE)
//   COIN_*       : coin_type encodings
//   coin_value() : unit value of a coin encoding (0 for the invalid code)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_5   = 2'b01;
  localparam logic [1:0] COIN_10  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] coin_type);
    logic [4:0] val;
    case (coin_type)
      COIN_1:  val = 5'd1;
      COIN_5:  val = 5'd5;
      COIN_10: val = 5'd10;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_fsm_change_hold_timer.sv
// change_hold_timer: loadable down-counter that times the change display window.
//   clk, rst_n : clock and asynchronous active-low reset
//   load_i     : load CHANGE_HOLD-1 (has priority over enable)
//   en_i       : decrement by one while the count is non-zero
//   done_o     : count has reached zero
module change_hold_timer #(
  parameter int CHANGE_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = (CHANGE_HOLD > 1) ? $clog2(CHANGE_HOLD) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CHANGE_HOLD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vend_change_fsm.sv
// vend_change_fsm: coin-accepting vending controller that feeds the change
// seven-segment decoder.
//   clk, rst_n       : clock and asynchronous active-low reset
//   coin_valid_i     : single-cycle coin strobe
//   coin_type_i[1:0] : 00=1, 01=5, 10=10 units, 11=invalid
//   cancel_i         : refund request, level sampled
//   credit_o[4:0]    : accumulated credit
//   dispense_o       : one-cycle vend pulse
//   change_amt_o[3:0]: change code to the decoder
//   change_valid_o   : change_amt_o is being presented
//   coin_reject_o    : pulse on the cycle after a rejected coin
//   busy_o           : in VEND or CHANGE
//
// state   | meaning
// IDLE    | no credit, waiting for a coin
// COLLECT | 0 < credit < PRICE, accepting coins or cancel
// VEND    | one-cycle dispense, change computed at exit
// CHANGE  | change/refund held for CHANGE_HOLD cycles
module vend_change_fsm
  import vend_pkg::*;
#(
  parameter int PRICE       = 7,
  parameter int CHANGE_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       cancel_i,
  output logic [4:0] credit_o,
  output logic       dispense_o,
  output logic [3:0] change_amt_o,
  output logic       change_valid_o,
  output logic       coin_reject_o,
  output logic       busy_o
);

  localparam logic [4:0] PRICE_U = 5'(PRICE);

  vend_state_e state_q, state_d;
  logic [4:0]  credit_q, credit_d;
  logic [3:0]  change_q, change_d;
  logic        reject_q, reject_d;
  logic        timer_load, timer_en, timer_done;
  logic        busy;
  logic        coin_ok;
  logic [4:0]  sum;

  assign busy = (state_q == VEND) || (state_q == CHANGE);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    coin_ok    = coin_valid_i && (coin_type_i != COIN_BAD);
    sum        = credit_q + coin_value(coin_type_i);
    // Coins arriving while busy are bounced, as are invalid codes anywhere.
    reject_d   = coin_valid_i && ((coin_type_i == COIN_BAD) || busy);

    case (state_q)
      IDLE, COLLECT: begin
        if (coin_ok) begin
          // Coin is added before cancel is considered; reaching the price wins.
          credit_d = sum;
          if (sum >= PRICE_U) begin
            state_d = VEND;
          end else if (cancel_i && (state_q == COLLECT)) begin
            change_d   = 4'(sum);
            credit_d   = '0;
            state_d    = CHANGE;
            timer_load = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else if (cancel_i && (state_q == COLLECT)) begin
          change_d   = 4'(credit_q);
          credit_d   = '0;
          state_d    = CHANGE;
          timer_load = 1'b1;
        end
      end
      VEND: begin
        credit_d = '0;
        change_d = 4'(credit_q - PRICE_U);
        if (credit_q > PRICE_U) begin
          state_d    = CHANGE;
          timer_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        if (timer_done) begin
          state_d  = IDLE;
          change_d = '0;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        change_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  change_hold_timer #(
    .CHANGE_HOLD(CHANGE_HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(timer_load),
    .en_i  (timer_en),
    .done_o(timer_done)
  );

  assign credit_o       = credit_q;
  assign dispense_o     = (state_q == VEND);
  assign change_amt_o   = change_q;
  assign change_valid_o = (state_q == CHANGE);
  assign coin_reject_o  = reject_q;
  assign busy_o         = busy;

endmodule

// File: tb/tb_vend_change_fsm.sv
module tb_vend_change_fsm;

  localparam int PRICE = 7;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic [4:0] credit;
  logic       dispense;
  logic [3:0] change_amt;
  logic       change_valid;
  logic       coin_reject;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: credit held, a pending vend flag, and the number of
  // change-display cycles still to be shown.
  int m_credit, m_change, m_hold, m_reject;
  bit m_vend;

  always #5 clk = ~clk;

  vend_change_fsm #(.PRICE(PRICE), .CHANGE_HOLD(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_valid_i  (coin_valid),
    .coin_type_i   (coin_type),
    .cancel_i      (cancel),
    .credit_o      (credit),
    .dispense_o    (dispense),
    .change_amt_o  (change_amt),
    .change_valid_o(change_valid),
    .coin_reject_o (coin_reject),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int value_of(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_change = 0; m_hold = 0; m_reject = 0; m_vend = 0;
  endtask

  task automatic check_all();
    chk("credit", int'(credit), m_credit);
    chk("dispense", int'(dispense), int'(m_vend));
    chk("change_amt", int'(change_amt), m_change);
    chk("change_valid", int'(change_valid), (m_hold > 0) ? 1 : 0);
    chk("coin_reject", int'(coin_reject), m_reject);
    chk("busy", int'(busy), (m_vend || m_hold > 0) ? 1 : 0);
  endtask

  task automatic model_advance(input logic cv, input logic [1:0] ct, input logic cn);
    bit m_busy;
    int sum, diff;
    m_busy   = m_vend || (m_hold > 0);
    m_reject = (cv && (ct == 2'b11 || m_busy)) ? 1 : 0;
    if (m_vend) begin
      diff     = m_credit - PRICE;
      m_credit = 0;
      m_vend   = 0;
      m_change = (diff > 0) ? diff : 0;
      m_hold   = (diff > 0) ? HOLD : 0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_change = 0;
    end else if (cv && ct != 2'b11) begin
      sum = m_credit + value_of(ct);
      if (sum >= PRICE) begin
        m_credit = sum;
        m_vend   = 1;
      end else if (cn && m_credit > 0) begin
        m_change = sum;
        m_credit = 0;
        m_hold   = HOLD;
      end else begin
        m_credit = sum;
      end
    end else if (cn && m_credit > 0) begin
      m_change = m_credit;
      m_credit = 0;
      m_hold   = HOLD;
    end
  endtask

  // Called at a falling edge: check present outputs, apply inputs for the
  // coming rising edge, advance the model, wait for the next falling edge.
  task automatic step(input logic cv, input logic [1:0] ct, input logic cn);
    check_all();
    coin_valid = cv;
    coin_type  = ct;
    cancel     = cn;
    model_advance(cv, ct, cn);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(10);

    // 5, 1, 1 -> exact price, no change
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("plan_exact_dispense", int'(dispense), 1);
    chk("plan_exact_credit", int'(credit), 7);
    idle(3);

    // 5, 10 -> change of 8
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk("plan_over_credit", int'(credit), 15);
    step(1'b0, 2'b00, 1'b0);
    chk("plan_change8", int'(change_amt), 8);
    idle(5);

    // 1 then cancel -> refund 1
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    chk("plan_refund1", int'(change_amt), 1);
    idle(5);

    // 1, then 5 together with cancel -> refund 6
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b1);
    chk("plan_refund6", int'(change_amt), 6);
    idle(5);

    // coin during CHANGE is rejected, change unaffected
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    chk("plan_reject_busy", int'(coin_reject), 1);
    chk("plan_reject_change", int'(change_amt), 8);
    idle(5);

    // invalid coin in IDLE
    step(1'b1, 2'b11, 1'b0);
    chk("plan_reject_bad", int'(coin_reject), 1);
    chk("plan_reject_credit", int'(credit), 0);
    idle(2);

    // async reset on the second CHANGE cycle
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("plan_pre_reset_change", int'(change_amt), 8);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_change_amt", int'(change_amt), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_busy", int'(busy), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b10, 1'b0);
    chk("resume_dispense", int'(dispense), 1);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic       cv, cn;
      logic [1:0] ct;
      cv = ($urandom_range(0, 99) < 45);
      ct = 2'($urandom_range(0, 3));
      cn = ($urandom_range(0, 99) < 20);
      step(cv, ct, cn);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
